// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack handshake, pipeline stall, lane steering and load extension.
// Optional build macro MISALIGN_CHK_EN adds misalign_o and traps misaligned half/word accesses.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] Memout_o,
    output logic        stall_o,
    output logic        bus_err_o
`ifdef MISALIGN_CHK_EN
    ,
    output logic        misalign_o
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     memout_q, memout_d;
    logic [3:0]      be_q, be_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [1:0]      lane_q, lane_d;
    logic [2:0]      f3_q, f3_d;
    logic            access;
    logic [3:0]      st_be;
    logic [31:0]     st_wdata;
`ifdef MISALIGN_CHK_EN
    logic            mis_q, mis_d;
    logic            misaligned;
`endif

    function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {lane, 3'b000};
        case (f3)
            3'b000:  ld_ext = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ld_ext = {24'h0, sh[7:0]};
            3'b001:  ld_ext = lane[1] ? {{16{rd[31]}}, rd[31:16]} : {{16{rd[15]}}, rd[15:0]};
            3'b101:  ld_ext = lane[1] ? {16'h0, rd[31:16]} : {16'h0, rd[15:0]};
            default: ld_ext = rd;
        endcase
    endfunction

    assign access = MemRead_i | MemWrite_i;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata_i;
        if (MemWrite_i) begin
            case (funct3_i)
                3'b000: begin
                    st_be    = 4'b0001 << addr_i[1:0];
                    st_wdata = {4{wdata_i[7:0]}};
                end
                3'b001: begin
                    st_be    = addr_i[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{wdata_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

`ifdef MISALIGN_CHK_EN
    // Store decoding wins when both strobes are set, so misalignment follows the same priority.
    always_comb begin
        misaligned = 1'b0;
        if (MemWrite_i) begin
            misaligned = ((funct3_i == 3'b001) && addr_i[0]) ||
                         ((funct3_i == 3'b010) && (addr_i[1:0] != 2'b00));
        end else if (MemRead_i) begin
            misaligned = (((funct3_i == 3'b001) || (funct3_i == 3'b101)) && addr_i[0]) ||
                         ((funct3_i == 3'b010) && (addr_i[1:0] != 2'b00));
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        memout_d = memout_q;
        be_d     = be_q;
        we_d     = we_q;
        lane_d   = lane_q;
        f3_d     = f3_q;
        err_d    = 1'b0;
        stall_o  = 1'b0;
`ifdef MISALIGN_CHK_EN
        mis_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
                    stall_o = 1'b1;
`ifdef MISALIGN_CHK_EN
                    if (misaligned) begin
                        state_d = DONE;
                        mis_d   = 1'b1;
                        if (!MemWrite_i) memout_d = '0;
                    end else begin
`else
                    begin
`endif
                        state_d = BUSY;
                        cnt_d   = '0;
                        addr_d  = {addr_i[31:2], 2'b00};
                        lane_d  = addr_i[1:0];
                        f3_d    = funct3_i;
                        we_d    = MemWrite_i;
                        be_d    = st_be;
                        wdata_d = st_wdata;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!we_q) memout_d = ld_ext(f3_q, lane_q, mem_rdata_i);
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    memout_d = '0;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            memout_q <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            lane_q   <= '0;
            f3_q     <= '0;
`ifdef MISALIGN_CHK_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            memout_q <= memout_d;
            be_q     <= be_d;
            we_q     <= we_d;
            err_q    <= err_d;
            lane_q   <= lane_d;
            f3_q     <= f3_d;
`ifdef MISALIGN_CHK_EN
            mis_q    <= mis_d;
`endif
        end
    end

    assign mem_req_o   = (state_q == BUSY);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign Memout_o    = memout_q;
    assign bus_err_o   = err_q;
`ifdef MISALIGN_CHK_EN
    assign misalign_o  = mis_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected results, a negedge monitor checks them.
module tb_mem_access_unit;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        MemRead_i = 1'b0, MemWrite_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_req_o, mem_we_o, stall_o, bus_err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, Memout_o;
    logic [3:0]  mem_be_o;
`ifdef MISALIGN_CHK_EN
    logic        misalign_o;
`endif

    mem_access_unit #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .Memout_o(Memout_o),
        .stall_o(stall_o), .bus_err_o(bus_err_o)
`ifdef MISALIGN_CHK_EN
        , .misalign_o(misalign_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic [31:0] memout;
        logic        err;
        logic        mis;
        int unsigned reqs;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] memout_model = '0;
    logic        mon_en = 1'b1;

    int unsigned cfg_lat = 1;
    logic        cfg_noack = 1'b0;
    logic [31:0] cfg_rdata = '0;
    logic        force_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Reference: what a load of the given size returns from a fetched word.
    function automatic logic [31:0] load_ref(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * a[1:0])) & 32'hFF;
        h = (rd >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 128) ? b - 32'd256 : b;
            3'd4: return b;
            3'd1: return (h >= 32768) ? h - 32'd65536 : h;
            3'd5: return h;
            default: return rd;
        endcase
    endfunction

    // Memory responder: acks on the cfg_lat-th request cycle, or never when cfg_noack.
    initial begin
        int unsigned rc = 0;
        forever begin
            @(negedge clk);
            mem_ack_i   = 1'b0;
            mem_rdata_i = $urandom;
            if (force_ack) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = cfg_rdata;
            end else if (mem_req_o) begin
                rc++;
                if (!cfg_noack && rc == cfg_lat) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = cfg_rdata;
                end
            end else begin
                rc = 0;
            end
        end
    end

    // Monitor: bus fields checked every request cycle, results checked when the stall drops.
    initial begin
        logic        prev = 1'b0;
        int unsigned sc = 0, rq = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev = 1'b0; sc = 0; rq = 0;
            end else begin
                if (mem_req_o) begin
                    rq++;
                    if (sb.size() > 0) begin
                        chk("bus_addr", mem_addr_o, sb[0].addr);
                        chk("bus_we", {31'b0, mem_we_o}, {31'b0, sb[0].we});
                        chk("bus_be", {28'b0, mem_be_o}, {28'b0, sb[0].be});
                        if (sb[0].we) chk("bus_wdata", mem_wdata_o, sb[0].wdata);
                    end
                end
                if (stall_o) sc++;
                if (prev && !stall_o) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_completion: got 1 expected 0");
                    end else begin
                        e = sb.pop_front();
                        chk("memout", Memout_o, e.memout);
                        chk("bus_err", {31'b0, bus_err_o}, {31'b0, e.err});
                        chk("req_cycles", rq, e.reqs);
                        chk("stall_cycles", sc, e.reqs + 1);
`ifdef MISALIGN_CHK_EN
                        chk("misalign", {31'b0, misalign_o}, {31'b0, e.mis});
`endif
                    end
                    sc = 0; rq = 0;
                end
                prev = stall_o;
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdata, input int unsigned lat, input logic noack);
        exp_t        e;
        int unsigned n;
        logic        mis;
        mis = 1'b0;
`ifdef MISALIGN_CHK_EN
        if (wr) mis = (f3 == 3'd1 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
        else    mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
`endif
        e.addr = a & 32'hFFFF_FFFC;
        e.we   = wr;
        e.be   = 4'hF;
        e.wdata = wd;
        if (wr && f3 == 3'd0) begin e.be = 4'(1 << a[1:0]); e.wdata = {4{wd[7:0]}}; end
        if (wr && f3 == 3'd1) begin e.be = a[1] ? 4'hC : 4'h3; e.wdata = {2{wd[15:0]}}; end
        e.mis = mis;
        e.err = 1'b0;
        if (mis) begin
            e.reqs = 0;
            if (!wr) memout_model = '0;
        end else if (noack) begin
            e.reqs = TO;
            e.err  = 1'b1;
            memout_model = '0;
        end else begin
            e.reqs = lat;
            if (!wr) memout_model = load_ref(f3, a, rdata);
        end
        e.memout = memout_model;
        sb.push_back(e);
        cfg_lat = lat; cfg_noack = noack; cfg_rdata = rdata;
        @(posedge clk); #1;
        MemRead_i = rd; MemWrite_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (stall_o && n < 60);
        if (stall_o) begin
            checks++; errors++;
            $display("FAIL completion_timeout: got stall after %0d cycles expected release", n);
        end
        MemRead_i = 1'b0; MemWrite_i = 1'b0; addr_i = $urandom; wdata_i = $urandom;
        repeat ($urandom_range(1, 3)) @(posedge clk);
    endtask

    initial begin
        logic        wr, rd;
        logic [31:0] a;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_be", {28'b0, mem_be_o}, 32'd0);
        chk("rst_memout", Memout_o, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        rst_i = 1'b0;

        issue(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0);
        issue(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 1, 0);
        issue(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF_1234, 2, 0);
        issue(1, 0, 3'd1, 32'h102, 32'h0, 32'h80FF_1234, 1, 0);
        issue(0, 1, 3'd1, 32'h206, 32'h0000ABCD, 32'h0, 1, 0);
        issue(1, 1, 3'd0, 32'h209, 32'h12345677, 32'hFFFFFFFF, 2, 0);
        issue(1, 0, 3'd2, 32'h104, 32'h0, 32'h0, 1, 1);
        issue(1, 0, 3'd5, 32'h10E, 32'h0, 32'h9ABC_7654, 4, 0);
`ifdef MISALIGN_CHK_EN
        issue(0, 1, 3'd2, 32'h301, 32'h55AA55AA, 32'h0, 1, 0);
`endif
        for (int i = 0; i < 150; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            a  = $urandom;
            issue(rd, wr, 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                  $urandom_range(1, 5), ($urandom_range(0, 9) == 0));
        end

        // Reset during the second busy cycle, then an ack that arrives after it.
        mon_en = 1'b0;
        cfg_noack = 1'b1;
        @(posedge clk); #1;
        MemRead_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_before_reset", {31'b0, mem_req_o}, 32'd1);
        rst_i = 1'b1; MemRead_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        cfg_rdata = 32'hCAFEF00D;
        force_ack = 1'b1;
        memout_model = '0;
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(posedge clk); #1;
        chk("mrst_req", {31'b0, mem_req_o}, 32'd0);
        chk("mrst_we", {31'b0, mem_we_o}, 32'd0);
        chk("mrst_be", {28'b0, mem_be_o}, 32'd0);
        chk("mrst_addr", mem_addr_o, 32'd0);
        chk("mrst_wdata", mem_wdata_o, 32'd0);
        chk("mrst_memout", Memout_o, memout_model);
        chk("mrst_stall", {31'b0, stall_o}, 32'd0);
        chk("mrst_err", {31'b0, bus_err_o}, 32'd0);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit of the 5-stage RISC-V pipeline. Sits between EX/MEM and MEM/WB.
- Turns MemRead/MemWrite from EX/MEM into a req/ack transaction on a variable-latency word-wide data memory.
- Stalls the pipeline until the transaction completes, then presents the load result (Memout) to the MEM/WB register.
- Handles byte/half/word stores and sign/zero-extended loads.

Parameters:
TIMEOUT, 16, max BUSY cycles waiting for mem_ack_i before bus error (>=1)
CNT_W, 5, width of wait counter (must hold TIMEOUT)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
MemRead_i  in  1  load request from EX/MEM
MemWrite_i  in  1  store request from EX/MEM
funct3_i  in  3  access size/sign (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010)
addr_i  in  32  byte address (ALU result)
wdata_i  in  32  store data (rs2)
mem_ack_i  in  1  memory completion, one-cycle pulse
mem_rdata_i  in  32  read word, valid with mem_ack_i
mem_req_o  out  1  request, held until ack or timeout
mem_we_o  out  1  1 = write
mem_addr_o  out  32  word address {addr[31:2],2'b00}
mem_wdata_o  out  32  lane-aligned store data
mem_be_o  out  4  byte enables
Memout_o  out  32  extended load result to MEM/WB
stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (sync, rst_i high at rising edge): state IDLE, wait counter 0. mem_req_o, mem_we_o, bus_err_o = 0. mem_addr_o, mem_wdata_o, Memout_o = 0. mem_be_o = 4'b0000. Applies mid-transaction too: BUSY is abandoned; an ack arriving later is ignored in IDLE.
- Access = MemRead_i | MemWrite_i. If both are set, the store is performed and the read is ignored.
- FSM:
  - IDLE: on access, register address, write data, enables, we, funct3 -> BUSY with mem_req_o=1. Otherwise stay.
  - BUSY: mem_ack_i -> DONE, req dropped. For a load, Memout_o <= extended lane of mem_rdata_i. Otherwise the counter increments. When counter == TIMEOUT-1 without ack -> DONE, Memout_o <= 0, bus_err_o pulses in DONE.
  - DONE: one cycle -> IDLE; counter cleared.
- stall_o (combinational) = (IDLE & access) | BUSY. Low in DONE, so the pipeline advances exactly once per access. Minimum stall 2 cycles (ack in first BUSY cycle).
- Memout_o holds its last value until the next completed load; stores do not modify it.
- Stores:
  - sb: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - sh: be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - sw / other: be = 1111, wdata unchanged.
- Loads: be = 1111. Select byte lane addr[1:0] or half lane addr[1]. lb/lh sign-extend, lbu/lhu zero-extend. lw and undefined funct3 return the full word.
- mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o are stable throughout BUSY.

Optional Feature:
MISALIGN_CHK_EN
- Defined: adds output misalign_o (1 bit, reset 0).
  - Misaligned when lh/lhu/sh has addr[0]=1, or lw/sw has addr[1:0]!=0.
  - In IDLE, a misaligned access goes directly to DONE. No mem_req_o, no memory write.
  - Memout_o <= 0 for a misaligned load.
  - misalign_o pulses in DONE. stall_o is high for exactly 1 cycle.
- Undefined: no misalign_o port; low address bits beyond lane select are ignored.

Test Plan:
- lw addr 0x100, memory acks 3 cycles after req, rdata 0xDEADBEEF -> mem_addr_o=0x100, be=1111, stall_o high 4 cycles, Memout_o=0xDEADBEEF in DONE, stall_o low there.
- lb addr 0x103, rdata 0x80FF_1234 -> Memout_o=0xFFFFFF80; lbu same -> 0x00000080; lh addr 0x102 -> 0xFFFF80FF.
- sh addr 0x206, wdata 0x0000ABCD, ack next cycle -> mem_we_o=1, be=1100, mem_wdata_o=0xABCDABCD, Memout_o unchanged.
- lw, no ack, TIMEOUT=16 -> mem_req_o high 16 cycles, then DONE with bus_err_o=1 one cycle, Memout_o=0, stall_o released.
- rst_i asserted in 2nd BUSY cycle, ack arrives next cycle -> all outputs 0, state IDLE, ack ignored, Memout_o stays 0.
- (MISALIGN_CHK_EN) sw addr 0x301 -> no mem_req_o, misalign_o=1 one cycle, stall_o high 1 cycle.
